// File: rtl/lsf_rbin_histogram_pkg.sv
// Shared widths, FSM state and score types for the LSF r-bin histogram.
// Build option LSF_HIST_NEIGHBOUR_SUM_EN widens the score to a 3-bin neighbourhood sum.
package lsf_hist_pkg;
    localparam int W_BIN        = 7;
    localparam int N_RBINS      = 2**W_BIN;
    localparam int W_CNT        = 4;
    localparam int CNT_SAT      = 2**W_CNT - 1;
    localparam int MIN_HITS_DEF = 3;
`ifdef LSF_HIST_NEIGHBOUR_SUM_EN
    localparam int W_SCORE      = W_CNT + 2;
`else
    localparam int W_SCORE      = W_CNT;
`endif

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [W_BIN-1:0]   bin_t;
    typedef logic [W_CNT-1:0]   cnt_t;
    typedef logic [W_SCORE-1:0] score_t;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == cnt_t'(CNT_SAT)) ? c : c + cnt_t'(1);
    endfunction
endpackage

// File: rtl/lsf_rbin_histogram_if.sv
// Hit-in / result-out bundle between the r-bin stage and one theta-slice histogram.
interface lsf_rbin_histogram_if;
    import lsf_hist_pkg::*;

    bin_t   r_bin;
    logic   r_bin_vld;
    logic   evt_end;
    logic   busy;
    bin_t   max_bin;
    score_t max_count;
    logic   found;
    logic   result_vld;
    logic   drop_err;

    modport master (
        output r_bin, r_bin_vld, evt_end,
        input  busy, max_bin, max_count, found, result_vld, drop_err
    );

    modport slave (
        input  r_bin, r_bin_vld, evt_end,
        output busy, max_bin, max_count, found, result_vld, drop_err
    );
endinterface

// File: rtl/lsf_hist_argmax.sv
// Running-max tracker over the bin scan; strict greater-than keeps the lowest index on ties.
module lsf_hist_argmax
    import lsf_hist_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_vld,
    input  score_t i_score,
    input  bin_t   i_index,
    input  logic   i_first,
    input  logic   i_last,
    output score_t o_nxt_count,
    output bin_t   o_max_bin,
    output score_t o_max_count
);
    bin_t   r_run_bin;
    score_t r_run_cnt;
    bin_t   w_base_bin;
    score_t w_base_cnt;
    bin_t   w_nxt_bin;
    logic   w_take;

    // First element compares against (bin 0, score 0) instead of stale state.
    always_comb begin
        w_base_bin  = i_first ? '0 : r_run_bin;
        w_base_cnt  = i_first ? '0 : r_run_cnt;
        w_take      = i_score > w_base_cnt;
        w_nxt_bin   = w_take ? i_index : w_base_bin;
        o_nxt_count = w_take ? i_score : w_base_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_bin   <= '0;
            r_run_cnt   <= '0;
            o_max_bin   <= '0;
            o_max_count <= '0;
        end else if (i_vld) begin
            r_run_bin <= w_nxt_bin;
            r_run_cnt <= o_nxt_count;
            if (i_last) begin
                o_max_bin   <= w_nxt_bin;
                o_max_count <= o_nxt_count;
            end
        end
    end
endmodule

// File: rtl/lsf_rbin_histogram.sv
// Per-theta-slice r-bin histogram: accumulate hits, scan-and-clear on evt_end, report argmax.
// LSF_HIST_NEIGHBOUR_SUM_EN scores each bin with its two neighbours (one extra flush cycle).
module lsf_rbin_histogram
    import lsf_hist_pkg::*;
#(
    parameter int W_bin_number_a = W_BIN,
    parameter int RBINS          = N_RBINS,
    parameter int MIN_HITS       = MIN_HITS_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    lsf_rbin_histogram_if.slave bus
);
    localparam int W_IDX = W_bin_number_a + 1;
`ifdef LSF_HIST_NEIGHBOUR_SUM_EN
    localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(RBINS);
`else
    localparam logic [W_IDX-1:0] LAST_IDX = W_IDX'(RBINS - 1);
`endif

    state_e                    r_state, w_state_nxt;
    logic [W_IDX-1:0]          r_idx;
    cnt_t                      r_cnt [RBINS];
    logic                      w_busy, w_scan, w_last, w_hit;
    logic [W_bin_number_a-1:0] w_rd_idx;
    cnt_t                      w_rd_cnt;
    logic                      w_am_vld, w_am_first;
    bin_t                      w_am_index;
    score_t                    w_score, w_nxt_count, w_max_count;
    bin_t                      w_max_bin;
    logic                      r_found, r_result_vld, r_drop_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (bus.evt_end) w_state_nxt = SCAN;
            SCAN:    if (w_last)      w_state_nxt = DONE;
            DONE:                     w_state_nxt = ACCUM;
            default:                  w_state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        w_busy = (r_state != ACCUM);
        w_scan = (r_state == SCAN);
        w_last = w_scan && (r_idx == LAST_IDX);
    end

    assign w_hit    = (r_state == ACCUM) && bus.r_bin_vld;
    assign w_rd_idx = r_idx[W_bin_number_a-1:0];

    // Single-cycle read-modify-write, so back-to-back hits to one bin never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RBINS; i++) r_cnt[i] <= '0;
        end else if (w_hit) begin
            r_cnt[bus.r_bin] <= sat_inc(r_cnt[bus.r_bin]);
        end else if (w_scan) begin
            r_cnt[w_rd_idx] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_idx <= '0;
        else if (w_scan) r_idx <= w_last ? '0 : r_idx + W_IDX'(1);
    end

`ifdef LSF_HIST_NEIGHBOUR_SUM_EN
    cnt_t r_h1, r_h2;

    // Two-deep history: reading bin j completes the score of bin j-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1 <= '0;
            r_h2 <= '0;
        end else if (w_scan) begin
            r_h2 <= r_h1;
            r_h1 <= w_rd_cnt;
        end else begin
            r_h1 <= '0;
            r_h2 <= '0;
        end
    end

    always_comb begin
        w_rd_cnt   = r_idx[W_bin_number_a] ? '0 : r_cnt[w_rd_idx];
        w_score    = score_t'(r_h2) + score_t'(r_h1) + score_t'(w_rd_cnt);
        w_am_vld   = w_scan && (r_idx != '0);
        w_am_index = bin_t'(r_idx - W_IDX'(1));
        w_am_first = (r_idx == W_IDX'(1));
    end
`else
    always_comb begin
        w_rd_cnt   = r_cnt[w_rd_idx];
        w_score    = score_t'(w_rd_cnt);
        w_am_vld   = w_scan;
        w_am_index = bin_t'(w_rd_idx);
        w_am_first = (r_idx == '0);
    end
`endif

    lsf_hist_argmax u_argmax (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_vld       (w_am_vld),
        .i_score     (w_score),
        .i_index     (w_am_index),
        .i_first     (w_am_first),
        .i_last      (w_last),
        .o_nxt_count (w_nxt_count),
        .o_max_bin   (w_max_bin),
        .o_max_count (w_max_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_found      <= 1'b0;
            r_result_vld <= 1'b0;
            r_drop_err   <= 1'b0;
        end else begin
            r_result_vld <= w_last;
            r_drop_err   <= w_busy && (bus.r_bin_vld || bus.evt_end);
            if (w_last) r_found <= (w_nxt_count >= score_t'(MIN_HITS));
        end
    end

    assign bus.busy       = w_busy;
    assign bus.max_bin    = w_max_bin;
    assign bus.max_count  = w_max_count;
    assign bus.found      = r_found;
    assign bus.result_vld = r_result_vld;
    assign bus.drop_err   = r_drop_err;
endmodule

// File: doc/lsf_rbin_histogram.md
Name: lsf_rbin_histogram

Overview:
- Downstream consumer of the per-hit r-bin stage in the Legendre segment finder (LSF).
- For one theta slice, accumulates hit counts per r bin over an event.
- On end-of-event, scans all bins and reports the winning bin (argmax) and its count, then leaves the histogram cleared for the next event.
- One instance per theta slice; its result feeds the LSF peak/segment selection.

Parameters:
- W_bin_number_a, 7, width of r_bin index.
- RBINS, 128, number of r bins; must equal 2**W_bin_number_a.
- W_CNT, 4, per-bin counter width; counters saturate.
- MIN_HITS, 3, minimum max_count for found=1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- r_bin  in  W_bin_number_a  bin index from the r-bin stage.
- r_bin_vld  in  1  r_bin qualifier; one hit per cycle maximum.
- evt_end  in  1  single-cycle pulse: all hits of the event delivered.
- busy  out  1  high in SCAN and DONE; hits are not accepted.
- max_bin  out  W_bin_number_a  winning bin; held until next result.
- max_count  out  W_CNT (W_CNT+2 with macro)  score of max_bin.
- found  out  1  max_count >= MIN_HITS.
- result_vld  out  1  one-cycle pulse when max_bin/max_count/found update.
- drop_err  out  1  one-cycle pulse per r_bin_vld or evt_end ignored while busy.

Behaviour:
- Reset (async, rst_n=0): all counters 0, state ACCUM, scan index 0, all outputs 0.
- Storage: register array RBINS x W_CNT. Read-modify-write is done in one cycle, so back-to-back hits to the same bin count correctly.
- FSM states: ACCUM, SCAN, DONE.
- ACCUM:
  - r_bin_vld=1 increments cnt[r_bin]; the counter saturates at 2**W_CNT-1.
  - evt_end=1 moves to SCAN. A hit in the same cycle as evt_end is counted.
- SCAN:
  - evt_end at cycle k; bin i is read and cleared to 0 at cycle k+1+i for i=0..RBINS-1.
  - Running max uses a strict greater-than comparison, so ties resolve to the lowest bin index. The running max is initialised to bin 0, score 0.
  - The last bin leads to DONE.
- DONE: lasts one cycle, at k+RBINS+1.
  - result_vld=1; max_bin, max_count and found are registered.
  - Returns to ACCUM; hits are accepted from k+RBINS+2.
- busy: high in SCAN and DONE.
  - r_bin_vld while busy: the hit is discarded and drop_err pulses.
  - evt_end while busy: ignored and drop_err pulses.
  - Both in the same cycle: a single drop_err pulse.
- Empty event (evt_end with no hits): max_bin=0, max_count=0, found=0, result_vld still pulses.
- After DONE, every counter is 0; no explicit clear cycle is needed.
- Reset mid-SCAN: state goes to ACCUM immediately, counters clear, no result_vld pulse.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: LSF_HIST_NEIGHBOUR_SUM_EN.
- Defined:
  - Score(i) = cnt[i-1] + cnt[i] + cnt[i+1], width W_CNT+2; out-of-range neighbours count as 0 (no wrap).
  - The scan keeps a 2-deep history and adds one flush cycle, so SCAN lasts RBINS+1 cycles and result_vld arrives at k+RBINS+2.
  - found compares the summed score against MIN_HITS.
- Undefined:
  - Score(i) = cnt[i]; latency as stated above.
  - max_count is W_CNT wide.

Decomposition:
- Package lsf_hist_pkg holds:
  - localparams for W_CNT and the saturation value;
  - typedef enum for the state (ACCUM, SCAN, DONE);
  - typedef for the score type (W_CNT or W_CNT+2 bits, selected by the macro).
- One sub-module, lsf_hist_argmax. It is the running-max tracker and takes:
  - score, index, first, last inputs;
  - produces max_bin and max_count;
  - applies the strict greater-than tie rule.

Test Plan:
Values: RBINS=128, W_CNT=4, MIN_HITS=3, macro off unless stated.
- Hits to bins 10,10,10,20,20, then evt_end at cycle k -> result_vld at k+129; max_bin=10, max_count=3, found=1; busy high k+1..k+129.
- Hits 5,5,7,7, then evt_end -> max_bin=5 (tie goes to the lower bin), max_count=2, found=0.
- 20 hits to bin 127 -> max_count=15 (saturated), max_bin=127. A second evt_end with no hits -> max_count=0, max_bin=0, found=0, proving clear-on-scan.
- r_bin_vld together with evt_end (bin 3), plus hits at k+5 and k+50 while busy -> bin 3 is counted; drop_err pulses exactly twice; the next event's result excludes the dropped hits.
- rst_n low at k+60 mid-scan -> outputs 0 asynchronously, no result_vld. After release, 3 hits to bin 40 and evt_end -> max_bin=40, max_count=3.
- Macro on, hits at bins 9 (x1), 10 (x2), 11 (x1), 50 (x3) -> max_bin=10, max_count=4, result_vld at k+130.
